// File: rtl/me_window_shifter_rev.sv
// me_window_shifter_rev: producer end of the reference-row sliding-window chain.
// A load captures a 16-pixel window plus an 8-pixel extension; the block then
// presents EXT_PIX+1 windows over a valid/ready handshake, sliding one pixel
// per accepted beat either forward (new pixel at the top) or reverse (new pixel
// at the bottom).
module me_window_shifter_rev #(
    parameter int PIX_W   = 8,
    parameter int WIN_PIX = 16,
    parameter int EXT_PIX = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               load_i,
    output logic                               load_rdy_o,
    input  logic [WIN_PIX*PIX_W-1:0]           win_data_i,
    input  logic [EXT_PIX*PIX_W-1:0]           ext_data_i,
    input  logic                               dir_i,
    output logic [WIN_PIX*PIX_W-1:0]           win_o,
    output logic                               win_vld_o,
    input  logic                               win_rdy_i,
    output logic [$clog2(EXT_PIX+1)-1:0]       shift_cnt_o,
    output logic                               done_o
);

    localparam int WIN_W = WIN_PIX * PIX_W;
    localparam int EXT_W = EXT_PIX * PIX_W;
    localparam int CNT_W = $clog2(EXT_PIX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXT_PIX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [WIN_W-1:0]   win_q;
    logic [EXT_W-1:0]   ext_q;
    logic               dir_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               slide;
    logic               last_beat;
    logic [WIN_W-1:0]   win_slid;
    logic [EXT_W-1:0]   ext_slid;

    // Handshake qualifiers: a beat is accepted only while EMIT presents a window.
    assign accept    = (state_q == ST_EMIT) && win_rdy_i;
    assign last_beat = (cnt_q == LAST_CNT);
    assign slide     = accept && !last_beat;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; outputs depend only on the state flops.
    always_comb begin
        state_nxt  = state_q;
        load_rdy_o = 1'b0;
        win_vld_o  = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_rdy_o = 1'b1;
                if (load_i) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                win_vld_o = 1'b1;
                if (win_rdy_i && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-pixel slide of window and extension in the stored direction.
    always_comb begin
        win_slid = win_q;
        ext_slid = ext_q;
        if (dir_q) begin
            win_slid = {win_q[WIN_W-PIX_W-1:0], ext_q[EXT_W-1 -: PIX_W]};
            ext_slid = ext_q << PIX_W;
        end else begin
            win_slid = {ext_q[PIX_W-1:0], win_q[WIN_W-1:PIX_W]};
            ext_slid = ext_q >> PIX_W;
        end
    end

    // Datapath registers: capture on load, slide on every non-final accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= '0;
            ext_q <= '0;
            dir_q <= 1'b0;
            cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && load_i) begin
            win_q <= win_data_i;
            ext_q <= ext_data_i;
            dir_q <= dir_i;
            cnt_q <= '0;
        end else if (slide) begin
            win_q <= win_slid;
            ext_q <= ext_slid;
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign win_o       = win_q;
    assign shift_cnt_o = cnt_q;

endmodule

// File: doc/me_window_shifter_rev.md
Name: me_window_shifter_rev

Overview:
- Producer end of the reference-row sliding-window chain in the motion-estimation datapath.
- Loads one 16-pixel search window plus an 8-pixel extension from reference memory.
- Emits EXT_PIX+1 successive windows over a valid/ready handshake, sliding one pixel per accepted beat.
- Slides toward the low pixel (forward scan, new pixel enters at the top byte) or toward the high pixel (reverse scan, new pixel enters at the bottom byte), selected per load.

Parameters:
- PIX_W, 8, bits per pixel.
- WIN_PIX, 16, pixels per output window (window width 128 bits at default).
- EXT_PIX, 8, extension pixels per load; equals the number of slides per load.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- load_i  in  1  load request; qualified by load_rdy_o.
- load_rdy_o  out  1  block can accept a load.
- win_data_i  in  WIN_PIX*PIX_W  initial window; pixel k at bits [PIX_W*k +: PIX_W].
- ext_data_i  in  EXT_PIX*PIX_W  extension pixels; pixel j at bits [PIX_W*j +: PIX_W].
- dir_i  in  1  slide direction: 0 forward, 1 reverse. Sampled with the load.
- win_o  out  WIN_PIX*PIX_W  current window.
- win_vld_o  out  1  win_o is valid.
- win_rdy_i  in  1  consumer accepts win_o.
- shift_cnt_o  out  clog2(EXT_PIX+1)  slides applied to the current win_o.
- done_o  out  1  one-cycle pulse after the final window is accepted.

Behaviour:
- Reset (rst_i=1 at a clock edge, any state, including mid-burst):
  - state returns to IDLE; the window and extension registers clear to 0.
  - win_o=0, win_vld_o=0, shift_cnt_o=0, done_o=0, load_rdy_o=1 in the following cycle.
  - The stored direction bit clears to 0.
- States: IDLE, EMIT, DONE.
- IDLE:
  - load_rdy_o=1, win_vld_o=0.
  - On load_i=1 at an edge: capture win_data_i, ext_data_i and dir_i; set shift_cnt=0; go to EMIT.
  - win_vld_o=1 with the unshifted window in the next cycle (load-to-valid latency is 1 cycle).
- EMIT:
  - load_rdy_o=0; load_i is ignored.
  - win_o and shift_cnt_o must stay stable while win_vld_o=1 and win_rdy_i=0.
- Accepted beat (win_vld_o and win_rdy_i at an edge):
  - If shift_cnt < EXT_PIX, slide once and increment shift_cnt. win_vld_o stays 1, so back-to-back beats run at 1 per cycle.
  - Forward (dir=0): win <= {ext[PIX_W-1:0], win[top:PIX_W]}; ext <= ext >> PIX_W.
  - Reverse (dir=1): win <= {win[top-PIX_W:0], ext[top -: PIX_W]}; ext <= ext << PIX_W.
  - Vacated extension bits fill with 0.
  - If shift_cnt == EXT_PIX, this is the final beat: go to DONE and drop win_vld_o next cycle.
- Total windows per load: exactly EXT_PIX+1.
- DONE:
  - Lasts one cycle; done_o=1 and win_vld_o=0.
  - win_o holds the last window.
  - Next state is IDLE, so load_rdy_o returns to 1 two cycles after the final accept.
  - A load cannot be accepted in DONE.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- win_rdy_i is a don't-care while win_vld_o=0.
- shift_cnt never exceeds EXT_PIX; no wrap-around.

Test Plan:
- Forward burst, win_rdy_i held 1:
  - Stimulus: win_data_i byte k = k (0x0F..0x00), ext_data_i byte j = 0x10+j, dir_i=0.
  - Beat 0: win_o = 0x0F0E...0100.
  - Beat 1: win_o = 0x100F0E...01.
  - Beat 8: win_o bytes 15..0 = 0x17..0x08.
  - 9 beats on consecutive cycles; done_o pulses the cycle after beat 8.
- Reverse burst, same data, dir_i=1:
  - Beat 1: win_o = 0x0E0D...0017.
  - Beat 8: high 8 bytes = 0x07..0x00, low 8 bytes = 0x17..0x10.
  - shift_cnt_o steps 0..8.
- Backpressure:
  - Stimulus: win_rdy_i toggles 1,0,0,1 during a burst.
  - win_o and shift_cnt_o hold across the stall cycles.
  - Still exactly 9 accepted beats, with no skipped or duplicated window.
- Load while busy:
  - Stimulus: assert load_i with different data during EMIT and during DONE.
  - Both loads are ignored; the burst completes with the original data.
  - A load issued the cycle after DONE is accepted.
- Reset mid-burst:
  - Stimulus: rst_i=1 after beat 3.
  - Next cycle: win_vld_o=0, win_o=0, shift_cnt_o=0, done_o=0, load_rdy_o=1.
  - A subsequent load starts again from beat 0.
- Back-to-back loads:
  - Stimulus: two loads, the second asserted as soon as load_rdy_o rises.
  - Second burst starts 1 cycle after the load.
  - The second burst's direction is independent of the first.
